// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between two requesters:
//   - Port A, the MEM/WB writeback. It has fixed priority and no backpressure.
//   - Port B, the long-latency units (mult/div, uncached loads). It delivers
//     results through a valid/ready handshake into a small FIFO.
// Queued writes drive RAW hazard flags back to ID. When the FIFO head is
// starved by continuous port-A traffic, a stall request asks the pipeline
// to issue a bubble.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   a_we, a_waddr, a_wdata    pipeline writeback request (address 0 = no-op)
//   b_valid, b_waddr, b_wdata multicycle result (address 0 = dropped)
//   b_ready                   FIFO can accept (not full)
//   raddr1, raddr2            ID read addresses
//   hazard1, hazard2          read address matches a live queued write
//   stall_req                 FIFO head starved, request a bubble
//   we, waddr, wdata          registered regfile write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              stall_req,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  // FIFO storage. A slot's valid bit is cleared either when it is popped or
  // when a younger port-A write to the same address kills it. A killed slot
  // keeps its place in the FIFO until it reaches the head and is skipped.
  logic [DEPTH-1:0]  vld_reg;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [STV_W-1:0]  starve_reg;

  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              stall_reg;

  logic              empty;
  logic              full;
  logic              grant_a;
  logic              head_vld;
  logic              head_dead;
  logic              next_vld;
  logic              push;
  logic              push_vld;
  logic              fifo_wr;
  logic [1:0]        pop_cnt;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [PTR_W-1:0]  sel_ptr;
  logic [DEPTH-1:0]  kill;
  logic [DEPTH-1:0]  popped;
  logic [DEPTH-1:0]  match1;
  logic [DEPTH-1:0]  match2;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign nxt_ptr   = rd_ptr_reg + PTR_W'(1);
  assign grant_a   = a_we && (a_waddr != '0);
  assign head_vld  = !empty && vld_reg[rd_ptr_reg];
  assign head_dead = !empty && !vld_reg[rd_ptr_reg];
  assign next_vld  = (count_reg >= CNT_W'(2)) && vld_reg[nxt_ptr];

  // b_ready looks only at registered occupancy. A pop in the same cycle does
  // not free a slot for a push until the following cycle.
  assign b_ready   = rst || !full;

  // Address-0 results complete the handshake but never occupy a slot.
  assign push      = b_valid && !full && (b_waddr != '0);

  // A result arriving in the same cycle that port A writes the same register
  // is older than the pipeline write, so it is enqueued already dead.
  assign push_vld  = !(grant_a && (a_waddr == b_waddr));

  // Pop selection. A dead head is discarded without using the write slot.
  // When port A is idle, the entry behind a dead head may be written in the
  // same cycle, so a kill does not open a bubble. At most one dead entry is
  // skipped per cycle.
  always_comb begin
    pop_cnt = 2'd0;
    fifo_wr = 1'b0;
    sel_ptr = rd_ptr_reg;
    if (!grant_a) begin
      if (head_vld) begin
        fifo_wr = 1'b1;
        pop_cnt = 2'd1;
      end else if (head_dead) begin
        pop_cnt = 2'd1;
        if (next_vld) begin
          fifo_wr = 1'b1;
          sel_ptr = nxt_ptr;
          pop_cnt = 2'd2;
        end
      end
    end else if (head_dead) begin
      pop_cnt = 2'd1;
    end
  end

  // Per-slot kill, pop and hazard match terms.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign kill[gi]   = grant_a && vld_reg[gi] && (addr_mem[gi] == a_waddr);
      assign popped[gi] = ((pop_cnt != 2'd0) && (rd_ptr_reg == PTR_W'(gi))) ||
                          ((pop_cnt == 2'd2) && (nxt_ptr == PTR_W'(gi)));
      assign match1[gi] = vld_reg[gi] && (addr_mem[gi] == raddr1);
      assign match2[gi] = vld_reg[gi] && (addr_mem[gi] == raddr2);
    end
  endgenerate

  // Entries already handed to the write port have left the FIFO. The regfile
  // bypass covers them, so they raise no hazard here.
  assign hazard1 = (raddr1 != '0) && (|match1);
  assign hazard2 = (raddr2 != '0) && (|match2);

  // Valid bits. The slot being pushed is never one being popped, because a
  // push only happens when the FIFO is not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_reg == PTR_W'(i))) begin
          vld_reg[i] <= push_vld;
        end else if (popped[i] || kill[i]) begin
          vld_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage. It needs no reset because the valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr_reg == PTR_W'(i))) begin
        addr_mem[i] <= b_waddr;
        data_mem[i] <= b_wdata;
      end
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so pointers wrap
  // naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_cnt);
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
      count_reg  <= count_reg - CNT_W'(pop_cnt) + CNT_W'(push);
    end
  end

  // Starvation. The counter runs only while a live head loses to port A.
  // It saturates at the limit. stall_req follows one cycle later, so it stays
  // up for the cycle in which the starved entry reaches the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= '0;
      stall_reg  <= 1'b0;
    end else begin
      stall_reg <= (starve_reg == STV_W'(STARVE_LIMIT));
      if (empty || head_dead || (pop_cnt != 2'd0) || kill[rd_ptr_reg]) begin
        starve_reg <= '0;
      end else if (head_vld && (starve_reg != STV_W'(STARVE_LIMIT))) begin
        starve_reg <= starve_reg + STV_W'(1);
      end
    end
  end

  // Registered write port. It reads zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= grant_a || fifo_wr;
      if (grant_a) begin
        waddr_reg <= a_waddr;
        wdata_reg <= a_wdata;
      end else if (fifo_wr) begin
        waddr_reg <= addr_mem[sel_ptr];
        wdata_reg <= data_mem[sel_ptr];
      end else begin
        waddr_reg <= '0;
        wdata_reg <= '0;
      end
    end
  end

  assign we        = we_reg;
  assign waddr     = waddr_reg;
  assign wdata     = wdata_reg;
  assign stall_req = stall_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Drives directed scenarios and then randomized traffic. Each cycle, every
// output is compared against a queue-based reference of the arbitration
// rules.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid;
  logic [ADDR_W-1:0] b_waddr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ready;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              hazard1;
  logic              hazard2;
  logic              stall_req;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
    .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
    .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata)
  );

  // Reference: FIFO contents in age order plus the expected registered outputs.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                vld;
  } entry_t;

  entry_t            q[$];
  bit                m_we;
  bit                m_stall;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int                m_starve;
  int                n_checks;
  int                n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input logic [ADDR_W-1:0] ra);
    if (ra == '0) return 1'b0;
    foreach (q[i]) if (q[i].vld && q[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one clock of the arbitration rules to the reference state.
  task automatic model_step();
    bit                ga, empty0, hv0, hk, popped, wr, full0;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    entry_t            e;
    if (rst) begin
      q.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0; m_stall = 0; m_starve = 0;
      return;
    end
    full0  = (q.size() == DEPTH);
    empty0 = (q.size() == 0);
    ga     = a_we && (a_waddr != '0);
    hv0    = !empty0 && q[0].vld;
    hk     = ga && hv0 && (q[0].addr == a_waddr);
    wr     = ga;
    wa     = ga ? a_waddr : '0;
    wd     = ga ? a_wdata : '0;
    popped = 0;
    if (!ga && !empty0) begin
      popped = 1;
      if (q[0].vld) begin
        wr = 1; wa = q[0].addr; wd = q[0].data;
        void'(q.pop_front());
      end else begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].vld) begin
          wr = 1; wa = q[0].addr; wd = q[0].data;
          void'(q.pop_front());
        end
      end
    end else if (ga && !empty0 && !q[0].vld) begin
      popped = 1;
      void'(q.pop_front());
    end
    if (ga) foreach (q[i]) if (q[i].addr == a_waddr) q[i].vld = 0;
    m_stall = (m_starve == LIMIT);
    if (empty0 || !hv0 || popped || hk) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (b_valid && !full0 && b_waddr != '0) begin
      e.addr = b_waddr; e.data = b_wdata; e.vld = !(ga && a_waddr == b_waddr);
      q.push_back(e);
    end
    m_we = wr; m_waddr = wa; m_wdata = wd;
  endtask

  // One clock: drive inputs, compare all outputs, then advance the reference.
  task automatic cycle(input bit r, input bit aw, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] ad, input bit bv,
                       input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    @(negedge clk);
    rst = r; a_we = aw; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
    #1;
    check_val("b_ready", b_ready, r ? 1'b1 : (q.size() < DEPTH));
    check_val("hazard1", hazard1, m_hazard(raddr1));
    check_val("hazard2", hazard2, m_hazard(raddr2));
    check_val("stall_req", stall_req, m_stall);
    check_val("we", we, m_we);
    if (m_we) begin
      check_val("waddr", waddr, m_waddr);
      check_val("wdata", wdata, m_wdata);
    end
    model_step();
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, 0, '0, '0);
  endtask

  bit                pend, acc, r_rand, aw_rand;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] pd;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1; a_we = 0; a_waddr = '0; a_wdata = '0;
    b_valid = 0; b_waddr = '0; b_wdata = '0; raddr1 = '0; raddr2 = '0;
    q.delete(); m_we = 0; m_waddr = '0; m_wdata = '0; m_stall = 0; m_starve = 0;

    cycle(1, 0, '0, '0, 0, '0, '0);
    cycle(1, 0, '0, '0, 0, '0, '0);
    idle();
    check_val("rst_waddr", waddr, 0);
    check_val("rst_wdata", wdata, 0);

    // B only: handshake at cycle 0, hazard in cycle 1, write in cycle 2.
    cycle(0, 0, '0, '0, 1, 5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    idle();
    check_val("bonly_haz_c1", hazard1, 1);
    idle();
    check_val("bonly_we", we, 1);
    check_val("bonly_waddr", waddr, 5);
    check_val("bonly_wdata", wdata, 32'hDEADBEEF);
    check_val("bonly_haz_c2", hazard1, 0);
    raddr1 = '0;
    idle();

    // Starvation: head (addr 3) becomes valid, then port A writes every cycle.
    cycle(0, 1, 5'd7, 32'h70, 1, 5'd3, 32'h33);
    for (int j = 0; j <= LIMIT + 1; j++) begin
      cycle(0, 1, 5'(8 + j), 32'(j), 0, '0, '0);
      check_val("starve_rise", stall_req, (j >= LIMIT + 1));
    end
    idle();
    check_val("starve_hold", stall_req, 1);
    idle();
    check_val("starve_we", we, 1);
    check_val("starve_waddr", waddr, 3);
    check_val("starve_stall", stall_req, 1);
    idle();
    check_val("starve_fall", stall_req, 0);

    // WAW kill: queued addr 9 is killed by port A; the entry behind it
    // (addr 10) is written without a bubble.
    cycle(0, 1, 5'd12, 32'hC, 1, 5'd9, 32'h11);
    raddr2 = 5'd9;
    cycle(0, 1, 5'd9, 32'h22, 1, 5'd10, 32'h33);
    check_val("waw_haz_before", hazard2, 1);
    idle();
    check_val("waw_waddr", waddr, 9);
    check_val("waw_wdata", wdata, 32'h22);
    check_val("waw_haz_after", hazard2, 0);
    idle();
    check_val("waw_next_waddr", waddr, 10);
    check_val("waw_next_wdata", wdata, 32'h33);
    raddr2 = '0;
    idle();

    // Full FIFO: a further push is held while full and accepted after the first pop.
    cycle(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20);
    cycle(0, 1, 5'd2, 32'h2, 1, 5'd21, 32'h21);
    cycle(0, 1, 5'd4, 32'h4, 1, 5'd22, 32'h22);
    check_val("full_ready0", b_ready, 0);
    cycle(0, 0, '0, '0, 1, 5'd22, 32'h22);
    check_val("full_ready_pop", b_ready, 0);
    cycle(0, 0, '0, '0, 1, 5'd22, 32'h22);
    check_val("full_ready1", b_ready, 1);
    idle();
    idle();
    check_val("full_last_waddr", waddr, 22);
    idle();

    // Address 0: the a_we slot goes to the FIFO; a b_waddr=0 push is dropped.
    cycle(0, 1, 5'd6, 32'h6, 1, 5'd17, 32'h17);
    cycle(0, 1, 5'd0, 32'h99, 1, 5'd0, 32'h55);
    check_val("a0_ready", b_ready, 1);
    idle();
    check_val("a0_fifo_waddr", waddr, 17);
    idle();
    check_val("a0_no_write", we, 0);
    idle();

    // Reset with two queued entries: nothing queued may ever be written.
    cycle(0, 1, 5'd1, 32'h1, 1, 5'd24, 32'h24);
    cycle(0, 1, 5'd2, 32'h2, 1, 5'd25, 32'h25);
    raddr1 = 5'd24;
    cycle(1, 1, 5'd3, 32'h3, 0, '0, '0);
    check_val("mid_rst_ready", b_ready, 1);
    for (int k = 0; k < 4; k++) begin
      idle();
      check_val("post_rst_we", we, 0);
      check_val("post_rst_haz", hazard1, 0);
      check_val("post_rst_stall", stall_req, 0);
    end
    raddr1 = '0;

    // Randomized traffic. The B source holds its request until it is accepted.
    pend = 0; pa = '0; pd = '0;
    for (int c = 0; c < 1500; c++) begin
      r_rand = ($urandom_range(0, 149) == 0);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; pa = 5'($urandom_range(0, 7)); pd = $urandom;
      end
      raddr1  = 5'($urandom_range(0, 7));
      raddr2  = 5'($urandom_range(0, 7));
      aw_rand = ((c % 100) < 35) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
      acc     = pend && (r_rand || q.size() < DEPTH);
      cycle(r_rand, aw_rand, 5'($urandom_range(0, 7)), $urandom, pend, pa, pd);
      if (acc) pend = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters.
  - Port A: the MEM/WB pipeline writeback. It has fixed priority and no backpressure.
  - Port B: long-latency units (mult/div, uncached loads). It uses a valid/ready handshake into a small FIFO.
- Sits between MEM/WB, the multicycle units, and the regfile write port.
- Also drives RAW hazard flags to ID for queued writes, and a stall request to the pipeline when port B starves.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 2, port-B FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, cycles the FIFO head may wait before stall_req asserts (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- a_we  in  1  pipeline write request.
- a_waddr  in  ADDR_W  pipeline write address.
- a_wdata  in  DATA_W  pipeline write data.
- b_valid  in  1  multicycle result valid.
- b_waddr  in  ADDR_W  multicycle write address.
- b_wdata  in  DATA_W  multicycle write data.
- b_ready  out  1  FIFO can accept (high when not full).
- raddr1  in  ADDR_W  ID read address 1.
- raddr2  in  ADDR_W  ID read address 2.
- hazard1  out  1  raddr1 matches a valid queued entry.
- hazard2  out  1  raddr2 matches a valid queued entry.
- stall_req  out  1  request that the pipeline issue a bubble (a_we=0).
- we  out  1  regfile write enable.
- waddr  out  ADDR_W  regfile write address.
- wdata  out  DATA_W  regfile write data.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: we=0, waddr=0, wdata=0, stall_req=0.
  - FIFO emptied: all valid bits 0, pointers 0, starve counter 0.
  - b_ready=1 while rst=1.
  - An in-flight B handshake in a reset cycle is dropped.
- Write port registers we/waddr/wdata, giving 1-cycle latency from grant to regfile.
- Grant each cycle:
  - If a_we=1 and a_waddr≠0: grant A.
  - Else if FIFO non-empty: grant FIFO head and pop it.
  - Else: we=0 next cycle.
- a_we with a_waddr=0 is ignored (no grant, we stays 0); the slot is free for the FIFO.
- B handshake: transfer when b_valid && b_ready.
  - b_ready = !full, combinational from registered state.
  - b_waddr=0: handshake completes but nothing is enqueued.
- Simultaneous push and pop on a full FIFO: the push is not accepted, because b_ready=0 is computed from the pre-pop state.
- Push into an empty FIFO: the entry cannot be popped in the same cycle. Earliest write is cycle+2 after the handshake.
- WAW kill: when A is granted with address X, every valid FIFO entry with waddr=X is invalidated in that cycle. The pipeline write is the younger one.
  - Invalid entries at the head are skipped on pop without consuming a write slot. At most one skip per cycle.
  - A killed entry still occupies space until popped.
- hazard1/hazard2: combinational.
  - hazard1 = (raddr1≠0) && any valid entry.waddr==raddr1. hazard2 is the same for raddr2.
  - Entries being written this cycle (already on we/waddr) do not count; the regfile bypass covers them.
- Starvation:
  - Counter increments each cycle the head is valid and not granted. It clears on pop, on an empty FIFO, or on kill of the head.
  - When the counter reaches STARVE_LIMIT, stall_req=1 (registered) from the next cycle. It drops the cycle after the head is popped.
  - If a_we=1 while stall_req=1, A still wins, so no write is ever lost.
- The counter saturates at STARVE_LIMIT; no wrap-around.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, rst=1 one cycle → we=0, b_ready=1, hazards 0, stall_req=0; no queued write ever appears.
- B only, A idle:
  - Handshake b_waddr=5, b_wdata=0xDEADBEEF at cycle 0 → we=1, waddr=5, wdata=0xDEADBEEF at cycle 2.
  - hazard1=1 for raddr1=5 during cycle 1 only.
- A priority and starvation:
  - Enqueue B addr 3, then hold a_we=1 (addr 7, 8, …) every cycle → stall_req rises STARVE_LIMIT+1 cycles after the head becomes valid.
  - Drop a_we → B write of addr 3 appears next cycle; stall_req falls one cycle later.
- WAW kill: enqueue B addr 9 (data 0x11) while A writes addr 9 (data 0x22) → only 0x22 written to 9; hazard on 9 clears; killed entry skipped, next entry written without a gap.
- Full FIFO: push DEPTH entries with A busy → b_ready=0; a further b_valid is held, not lost, and accepted the cycle after the first pop.
- Address-0 cases: a_we=1 with a_waddr=0 and FIFO non-empty → FIFO head written that cycle; B push with waddr=0 → b_ready handshake completes, no write, no hazard.
